mac_stop_accum: RTL and testbench
=================================

// Module: mac_stop_accum
// PURPOSE
//  Accumulate stage of the matrix-multiply datapath (C = A x B, A is MxK, B is KxN).
//  Consumes one registered product A[i][k]*B[k][j] per beat and sums the K products of each C[i][j].
//  Emits one write into matrix C memory per element and stops after the last element.
//  Sits between the multiplier stage (mult_done_reg, product_reg, index registers) and C RAM.
// PARAMETERS
//  M                        4        rows of A and C (>=2)
//  K                        4        inner dimension (>=2)
//  N                        4        cols of B and C (>=2)
//  DATA_WIDTH_INIT_MATRIX   32       element width of A and B
//  DATA_WIDTH_RESULT_MATRIX 2*DATA_WIDTH_INIT_MATRIX+$clog2(K)   C element and accumulator width
// PORTS
//  clk                            in   1          clock, all logic on rising edge
//  reset                          in   1          synchronous, active-high reset
//  product_reg                    in   2*DW_INIT  unsigned product for this beat
//  matrix_a_col_addr_counter_reg  in   clog2(K)   k index (A column)
//  matrix_b_row_addr_counter_reg  in   clog2(K)   k index (B row)
//  matrix_a_row_addr_counter_reg  in   clog2(M)   i index
//  matrix_b_col_addr_counter_reg  in   clog2(N)   j index
//  mult_done_reg                  in   1          beat valid; inputs sampled when high
//  data_out_c                     out  DW_RESULT  finished C[i][j]
//  matrix_c_we                    out  1          one-cycle write strobe for C RAM
//  mac_done                       out  1          sticky: all M*N elements written
//  row_addr_c                     out  clog2(M)   write row i
//  col_addr_c                     out  clog2(N)   write col j
// BEHAVIOUR
//  - Reset (sync, active-high): accumulator, data_out_c, row/col_addr_c = 0; matrix_c_we = 0; mac_done = 0.
//  - Reset wins over a simultaneous beat. Reset mid-element discards the partial sum.
//  - Beat = rising edge with mult_done_reg=1 and mac_done=0. With no beat, all state holds and matrix_c_we = 0.
//  - k = matrix_a_col_addr_counter_reg. On k==0: acc <= zero-extended product (restart, drops any partial sum).
//  - On 0<k<K-1: acc <= acc + product.
//  - On k==K-1: data_out_c <= acc + product, row_addr_c <= i, col_addr_c <= j, matrix_c_we <= 1 for exactly one cycle.
//    acc is then don't-care until the next k==0.
//  - Latency: C write appears on the cycle after the edge that samples the k==K-1 beat.
//    Back-to-back elements are allowed (one beat per cycle, no bubbles).
//  - mac_done <= 1 on the same edge as the write whose i==M-1 and j==N-1. It stays high until reset.
//    Later beats are ignored (stop).
//  - Arithmetic is unsigned. DW_RESULT covers K full-scale products, so no overflow or wrap handling.
//  - Elements may arrive in any (i,j) order. Each element's k must run 0..K-1 in ascending order.
//  - Out-of-order k is not detected, except as described under CONFIGURATION.
// CONFIGURATION
//  MAC_INDEX_CHECK_EN defined:
//    - Adds output index_err (1 bit, reset 0, sticky).
//    - A beat with a_col != b_row sets index_err and is dropped: no accumulate, no write.
//  MAC_INDEX_CHECK_EN undefined:
//    - No index_err port. matrix_b_row_addr_counter_reg is unused and only a_col is used as k.
// STRUCTURE
//  - Package mac_pkg: result-width function (2*DW+$clog2(K)), index width localparams, and an
//    element-position typedef struct {row, col, k}.
//  - Sub-module mac_accumulator: owns the acc register and the clear/add/finish datapath.
//  - Top level keeps the beat qualification, write strobe, address capture and done/stop logic.
// TESTING (M=N=K=4, DW=32)
//  - Reset: hold reset 2 cycles with mult_done_reg=1 -> all outputs 0, no we pulse.
//  - Element (0,0): products 28,18,25,16 for k=0..3 -> one we pulse, data_out_c=87, row=0, col=0.
//  - Element (0,1): products 24,21,40,10 back-to-back -> data_out_c=95, col_addr_c=1.
//    we stays low during k=0..2.
//  - Full 64-beat sweep in row-major order -> exactly 16 we pulses with correct sums.
//    mac_done rises with the (3,3) write; extra beats afterwards cause no we.
//  - Gap and restart: deassert mult_done_reg mid-element -> no change.
//    A fresh k=0 beat discards the partial sum. Products 0xFFFFFFFF_FFFFFFFF x4 -> 0x3_FFFFFFFF_FFFFFFFC.
//  - Reset after k=2 of element (1,2), then restart it -> sum excludes the pre-reset beats and mac_done=0.
//    With MAC_INDEX_CHECK_EN: a beat with a_col=1, b_row=2 -> index_err=1, beat dropped.

Source files
------------

// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mac_pkg
//  Purpose  : Shared helpers for the matrix-multiply accumulate stage:
//             result-width and index-width functions, plus the element
//             position record {row, col, k} carried with each beat.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package mac_pkg;

  // Widest index any instance may use; per-instance widths are narrower and
  // are extracted from the low bits of each field.
  localparam int IDX_MAX_W = 16;

  // Accumulator/result width: a full-scale product is 2*dw bits and summing
  // k of them needs clog2(k) extra bits.
  function automatic int result_width(input int dw, input int k);
    return 2 * dw + $clog2(k);
  endfunction

  // Index width, kept at least 1 bit so degenerate sizes stay legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic [IDX_MAX_W-1:0] row;
    logic [IDX_MAX_W-1:0] col;
    logic [IDX_MAX_W-1:0] k;
  } elem_pos_t;

endpackage
`default_nettype wire

// File: rtl/mac_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : mac_accumulator
//  Purpose  : Accumulator register plus the clear/add/finish datapath for
//             one C element.
//  Ports    : clk, reset  - clock, synchronous active-high reset
//             en          - accept this beat's product
//             clear       - first product of an element (restart the sum)
//             product     - unsigned product for this beat
//             sum         - acc + product (combinational); the finished
//                           element value when the beat is the last k
//  Revision : 1.0 - initial release
// ============================================================================
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int PROD_WIDTH   = 64,
  parameter int RESULT_WIDTH = 66
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    clear,
  input  logic [PROD_WIDTH-1:0]   product,
  output logic [RESULT_WIDTH-1:0] sum
);

  logic [RESULT_WIDTH-1:0] acc;
  logic [RESULT_WIDTH-1:0] product_ext;

  assign product_ext = RESULT_WIDTH'(product);
  assign sum         = acc + product_ext;

  // On the last k the register still takes the sum; its content is
  // irrelevant afterwards because the next element starts with a clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (en) begin
      acc <= clear ? product_ext : sum;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mac_stop_accum.sv
`default_nettype none
// ============================================================================
//  Module   : mac_stop_accum
//  Purpose  : Accumulate stage of C = A x B. Sums the K products of each
//             C[i][j], emits one C RAM write per element and stops once all
//             M*N elements have been written.
//  Ports    : clk, reset                    - clock, sync active-high reset
//             product_reg                   - unsigned product for the beat
//             matrix_a_col_addr_counter_reg - k (A column)
//             matrix_b_row_addr_counter_reg - k (B row), used only by the
//                                             optional index check
//             matrix_a_row_addr_counter_reg - i
//             matrix_b_col_addr_counter_reg - j
//             mult_done_reg                 - beat valid
//             data_out_c, row_addr_c,
//             col_addr_c, matrix_c_we       - C RAM write port
//             mac_done                      - sticky, all elements written
//             index_err                     - sticky, only with the macro
//  Config   : MAC_INDEX_CHECK_EN - compare A column against B row per beat;
//             mismatching beats are dropped and raise index_err.
//  Revision : 1.0 - initial release
// ============================================================================
module mac_stop_accum
  import mac_pkg::*;
#(
  parameter int M                        = 4,
  parameter int K                        = 4,
  parameter int N                        = 4,
  parameter int DATA_WIDTH_INIT_MATRIX   = 32,
  parameter int DATA_WIDTH_RESULT_MATRIX = result_width(DATA_WIDTH_INIT_MATRIX, K)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [2*DATA_WIDTH_INIT_MATRIX-1:0] product_reg,
  input  logic [$clog2(K)-1:0]                matrix_a_col_addr_counter_reg,
  input  logic [$clog2(K)-1:0]                matrix_b_row_addr_counter_reg,
  input  logic [$clog2(M)-1:0]                matrix_a_row_addr_counter_reg,
  input  logic [$clog2(N)-1:0]                matrix_b_col_addr_counter_reg,
  input  logic                                mult_done_reg,
  output logic [DATA_WIDTH_RESULT_MATRIX-1:0] data_out_c,
  output logic                                matrix_c_we,
  output logic                                mac_done,
  output logic [$clog2(M)-1:0]                row_addr_c,
  output logic [$clog2(N)-1:0]                col_addr_c
`ifdef MAC_INDEX_CHECK_EN
  ,
  output logic                                index_err
`endif
);

  localparam int MW = idx_width(M);
  localparam int NW = idx_width(N);
  localparam int PW = 2 * DATA_WIDTH_INIT_MATRIX;

  elem_pos_t                         pos;
  logic                              beat;
  logic                              k_first;
  logic                              k_last;
  logic                              last_elem;
  logic [DATA_WIDTH_RESULT_MATRIX-1:0] sum;

  assign pos.row = IDX_MAX_W'(matrix_a_row_addr_counter_reg);
  assign pos.col = IDX_MAX_W'(matrix_b_col_addr_counter_reg);
  assign pos.k   = IDX_MAX_W'(matrix_a_col_addr_counter_reg);

  assign k_first   = (pos.k == '0);
  assign k_last    = (pos.k == IDX_MAX_W'(K - 1));
  assign last_elem = (pos.row == IDX_MAX_W'(M - 1)) && (pos.col == IDX_MAX_W'(N - 1));

`ifdef MAC_INDEX_CHECK_EN
  logic idx_match;
  assign idx_match = (matrix_a_col_addr_counter_reg == matrix_b_row_addr_counter_reg);
  // A mismatching beat never reaches the accumulator or the write port.
  assign beat      = mult_done_reg && !mac_done && idx_match;

  always_ff @(posedge clk) begin
    if (reset) begin
      index_err <= 1'b0;
    end else if (mult_done_reg && !mac_done && !idx_match) begin
      index_err <= 1'b1;
    end
  end
`else
  // The B row index only matters to the optional check.
  logic unused_b_row;
  assign unused_b_row = ^matrix_b_row_addr_counter_reg;
  assign beat         = mult_done_reg && !mac_done;
`endif

  mac_accumulator #(
    .PROD_WIDTH   (PW),
    .RESULT_WIDTH (DATA_WIDTH_RESULT_MATRIX)
  ) u_acc (
    .clk     (clk),
    .reset   (reset),
    .en      (beat),
    .clear   (k_first),
    .product (product_reg),
    .sum     (sum)
  );

  // Write port: the strobe is a single-cycle pulse raised by the edge that
  // samples the last-k beat; done is raised on the same edge as the final
  // element's write and then gates off every later beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_c  <= '0;
      row_addr_c  <= '0;
      col_addr_c  <= '0;
      matrix_c_we <= 1'b0;
      mac_done    <= 1'b0;
    end else begin
      matrix_c_we <= 1'b0;
      if (beat && k_last) begin
        data_out_c  <= sum;
        row_addr_c  <= pos.row[MW-1:0];
        col_addr_c  <= pos.col[NW-1:0];
        matrix_c_we <= 1'b1;
        if (last_elem) begin
          mac_done <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mac_stop_accum.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mac_stop_accum
//  Purpose  : Self-checking bench for mac_stop_accum (M=N=K=4, DW=32).
//             Expected writes are queued as beats are driven and compared
//             when the DUT strobes matrix_c_we.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mac_stop_accum;

  localparam int RW = 66;

  typedef struct {
    logic [RW-1:0] data;
    logic [1:0]    row;
    logic [1:0]    col;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [63:0]   product_reg;
  logic [1:0]    a_col, b_row, a_row, b_col;
  logic          mult_done_reg;
  logic [RW-1:0] data_out_c;
  logic          matrix_c_we;
  logic          mac_done;
  logic [1:0]    row_addr_c, col_addr_c;
`ifdef MAC_INDEX_CHECK_EN
  logic          index_err;
`endif

  exp_t q[$];
  int   n_chk   = 0;
  int   n_pass  = 0;
  int   n_push  = 0;
  int   n_we    = 0;
  logic exp_done = 1'b0;

  always #5 clk = ~clk;

  mac_stop_accum dut (
    .clk                           (clk),
    .reset                         (reset),
    .product_reg                   (product_reg),
    .matrix_a_col_addr_counter_reg (a_col),
    .matrix_b_row_addr_counter_reg (b_row),
    .matrix_a_row_addr_counter_reg (a_row),
    .matrix_b_col_addr_counter_reg (b_col),
    .mult_done_reg                 (mult_done_reg),
    .data_out_c                    (data_out_c),
    .matrix_c_we                   (matrix_c_we),
    .mac_done                      (mac_done),
    .row_addr_c                    (row_addr_c),
    .col_addr_c                    (col_addr_c)
`ifdef MAC_INDEX_CHECK_EN
    ,
    .index_err                     (index_err)
`endif
  );

  task automatic chk(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Scoreboard: every strobe must match the oldest outstanding write.
  always @(negedge clk) begin
    if (matrix_c_we === 1'b1) begin
      exp_t e;
      n_we++;
      if (q.size() == 0) begin
        chk("spurious_we", 1, 0);
      end else begin
        e = q.pop_front();
        chk("data_out_c", data_out_c, e.data);
        chk("row_addr_c", RW'(row_addr_c), RW'(e.row));
        chk("col_addr_c", RW'(col_addr_c), RW'(e.col));
        chk("mac_done_with_we", RW'(mac_done), RW'(e.last));
      end
    end
  end

  // One beat: inputs change 1 time unit after a rising edge, so the next
  // rising edge samples them.
  task automatic beat(input int i, input int j, input int k, input logic [63:0] p);
    mult_done_reg = 1'b1;
    a_row = 2'(i); b_col = 2'(j); a_col = 2'(k); b_row = 2'(k);
    product_reg = p;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int cycles);
    mult_done_reg = 1'b0;
    repeat (cycles) begin @(posedge clk); #1; end
  endtask

  task automatic push_exp(input int i, input int j, input logic [RW-1:0] s);
    exp_t e;
    if (!exp_done) begin
      e.data = s; e.row = 2'(i); e.col = 2'(j);
      e.last = (i == 3 && j == 3);
      q.push_back(e);
      n_push++;
      if (e.last) exp_done = 1'b1;
    end
  endtask

  // Full element, back-to-back beats k=0..3.
  task automatic elem(input int i, input int j, input logic [63:0] p0, input logic [63:0] p1,
                      input logic [63:0] p2, input logic [63:0] p3, input logic [RW-1:0] s);
    push_exp(i, j, s);
    beat(i, j, 0, p0); beat(i, j, 1, p1); beat(i, j, 2, p2); beat(i, j, 3, p3);
    mult_done_reg = 1'b0;
  endtask

  // Bounded wait for the scoreboard to empty.
  task automatic drain(input string tag);
    int n = 0;
    while (q.size() != 0 && n < 10) begin @(posedge clk); #1; n++; end
    @(negedge clk); @(posedge clk); #1;
    chk(tag, RW'(q.size()), 0);
  endtask

  initial begin
    logic [63:0] p[4];
    logic [RW-1:0] s;

    // Reset held two cycles with a valid last-k beat on the inputs.
    reset = 1'b1; mult_done_reg = 1'b1; product_reg = 64'd99;
    a_col = 2'd3; b_row = 2'd3; a_row = 2'd3; b_col = 2'd3;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0; mult_done_reg = 1'b0;
    @(negedge clk);
    chk("rst_data", data_out_c, 0);
    chk("rst_we", RW'(matrix_c_we), 0);
    chk("rst_done", RW'(mac_done), 0);
    chk("rst_row", RW'(row_addr_c), 0);
    chk("rst_col", RW'(col_addr_c), 0);
    @(posedge clk); #1;

    elem(0, 0, 28, 18, 25, 16, 87);
    drain("drain_e00");
    elem(0, 1, 24, 21, 40, 10, 95);
    drain("drain_e01");

    // Partial element, gap, then restart with full-scale products.
    beat(1, 0, 0, 100); beat(1, 0, 1, 200);
    idle(3);
    @(negedge clk);
    chk("gap_we", RW'(matrix_c_we), 0);
    chk("gap_data_hold", data_out_c, 95);
    @(posedge clk); #1;
    elem(1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
         64'hFFFF_FFFF_FFFF_FFFF, 66'h3_FFFF_FFFF_FFFF_FFFC);
    drain("drain_max");

    // Reset in the middle of element (1,2).
    beat(1, 2, 0, 5); beat(1, 2, 1, 6); beat(1, 2, 2, 7);
    mult_done_reg = 1'b0; reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("midrst_done", RW'(mac_done), 0);
    chk("midrst_data", data_out_c, 0);
    @(posedge clk); #1;
    elem(1, 2, 1, 2, 3, 4, 10);
    drain("drain_e12");

`ifdef MAC_INDEX_CHECK_EN
    mult_done_reg = 1'b1; a_row = 2'd2; b_col = 2'd2; a_col = 2'd1; b_row = 2'd2;
    product_reg = 64'd7;
    @(posedge clk); #1 mult_done_reg = 1'b0;
    @(negedge clk);
    chk("index_err", RW'(index_err), 1);
    @(posedge clk); #1;
    // Mismatching k=3 must also produce no write.
    mult_done_reg = 1'b1; a_col = 2'd3; b_row = 2'd0;
    @(posedge clk); #1 mult_done_reg = 1'b0;
    drain("drain_idx");
`endif

    // Full row-major sweep with random products.
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        s = '0;
        for (int k = 0; k < 4; k++) begin
          p[k] = {$urandom, $urandom};
          s = s + RW'(p[k]);
        end
        elem(i, j, p[0], p[1], p[2], p[3], s);
      end
    end
    drain("drain_sweep");
    chk("done_after_sweep", RW'(mac_done), 1);

    // Beats after done are ignored.
    elem(0, 0, 1, 1, 1, 1, 4);
    elem(3, 3, 2, 2, 2, 2, 8);
    idle(3);
    chk("no_we_after_done", RW'(q.size()), 0);
    chk("we_count", RW'(n_we), RW'(n_push));
    chk("done_sticky", RW'(mac_done), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
